simd_alu4_pipe: RTL and testbench

- Pipelined, runtime-configurable SIMD 4-operand adder/accumulator for the PIRDSP datapath.
- Next generation of the combinational W+X+Y+Z SIMD ALU: parametrised width and lane count, SIMD mode selected per sample, registered pipeline with valid tagging, per-lane accumulator, cascade carry-in/out.
- Sits after the multiplier partial-product stage and feeds the DSP output register.

---
 rtl/simd_alu_pkg.sv | 37 +++
 rtl/simd_lane_adder.sv | 38 +++
 rtl/simd_alu4_pipe.sv | 147 ++++++++++++++
 tb/tb_simd_alu4_pipe.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/simd_alu_pkg.sv
// Shared encodings and lane-mask helpers for the pipelined SIMD 4-operand adder.
// The lane masks are built for exactly four physical LaneW segments.
package simd_alu_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    OP_SUM4  = 2'b00,
    OP_SUM4C = 2'b01,
    OP_ACC   = 2'b10,
    OP_LOAD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    MODE_1L   = 2'b00,
    MODE_2L   = 2'b01,
    MODE_4L   = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // Bit i set: physical segment i is the lowest segment of a lane (carries stop below it).
  function automatic logic [NUM_LANES-1:0] lane_base_mask(input logic [1:0] mode);
    logic [NUM_LANES-1:0] m;
    case (mode)
      MODE_2L: m = 4'b0101;
      MODE_4L: m = 4'b1111;
      default: m = 4'b0001;
    endcase
    return m;
  endfunction

  // Bit i set: physical segment i is the top segment of a lane (where guard bits live).
  function automatic logic [NUM_LANES-1:0] lane_top_mask(input logic [NUM_LANES-1:0] base);
    return {1'b1, base[NUM_LANES-1:1]};
  endfunction

endpackage

// File: rtl/simd_lane_adder.sv
// Combinational lane-segmented adder: a + b (+ cin into segment 0), carries confined to
// lanes, with 2 guard bits per lane held at the lane's top segment.
module simd_lane_adder #(
  parameter int Width    = 48,
  parameter int NumLanes = 4
) (
  input  logic [Width-1:0]      a,
  input  logic [Width-1:0]      b,
  input  logic [2*NumLanes-1:0] ga,
  input  logic [2*NumLanes-1:0] gb,
  input  logic [1:0]            cin,
  input  logic [NumLanes-1:0]   base_mask,
  input  logic [NumLanes-1:0]   top_mask,
  output logic [Width-1:0]      sum,
  output logic [2*NumLanes-1:0] gsum
);

  localparam int LaneW = Width / NumLanes;

  always_comb begin
    logic [1:0]       carry;
    logic [LaneW+1:0] seg;
    carry = 2'b00;
    seg   = '0;
    sum   = '0;
    gsum  = '0;
    for (int i = 0; i < NumLanes; i++) begin
      // A lane base restarts the carry chain; only the lowest lane may see cin.
      if (base_mask[i]) carry = (i == 0) ? cin : 2'b00;
      seg = {2'b00, a[i*LaneW +: LaneW]} + {2'b00, b[i*LaneW +: LaneW]}
          + {{LaneW{1'b0}}, carry};
      sum[i*LaneW +: LaneW] = seg[LaneW-1:0];
      carry = seg[LaneW+1:LaneW];
      if (top_mask[i]) gsum[2*i +: 2] = ga[2*i +: 2] + gb[2*i +: 2] + carry;
    end
  end

endmodule

// File: rtl/simd_alu4_pipe.sv
// Pipelined SIMD W+X+Y+Z adder/accumulator: input capture, W+X+Y stage, result stage
// with a single-cycle accumulator loop. Latency 2 edges after acceptance.
module simd_alu4_pipe
  import simd_alu_pkg::*;
#(
  parameter int Width    = 48,
  parameter int NumLanes = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [Width-1:0]      W,
  input  logic [Width-1:0]      X,
  input  logic [Width-1:0]      Y,
  input  logic [Width-1:0]      Z,
  input  logic [1:0]            op,
  input  logic [1:0]            simd_mode,
  input  logic [1:0]            cin,
  output logic                  out_valid,
  output logic [Width-1:0]      S,
  output logic [2*NumLanes-1:0] cout,
  output logic [1:0]            cascade_cout
);

  // Valid semantics: a sample is taken on every edge where in_valid=1 (no ready, no stall);
  // its valid bit rides each stage and out_valid pulses for exactly one cycle per sample.

  logic             v_in_q;
  logic [Width-1:0] w_q, x_q, y_q, z_q;
  logic [1:0]       op_q, mode_q, cin_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_in_q <= 1'b0;
      w_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      op_q   <= 2'b00;
      mode_q <= 2'b00;
      cin_q  <= 2'b00;
    end else begin
      v_in_q <= in_valid;
      if (in_valid) begin
        w_q    <= W;
        x_q    <= X;
        y_q    <= Y;
        z_q    <= Z;
        op_q   <= op;
        mode_q <= simd_mode;
        cin_q  <= cin;
      end
    end
  end

  logic [NumLanes-1:0]   base1, top1;
  logic [Width-1:0]      wx_sum, p_sum;
  logic [2*NumLanes-1:0] wx_g, p_g;

  assign base1 = lane_base_mask(mode_q);
  assign top1  = lane_top_mask(base1);

  simd_lane_adder #(.Width(Width), .NumLanes(NumLanes)) u_add_wx (
    .a(w_q), .b(x_q), .ga('0), .gb('0), .cin(2'b00),
    .base_mask(base1), .top_mask(top1), .sum(wx_sum), .gsum(wx_g)
  );

  simd_lane_adder #(.Width(Width), .NumLanes(NumLanes)) u_add_p (
    .a(wx_sum), .b(y_q), .ga(wx_g), .gb('0), .cin(2'b00),
    .base_mask(base1), .top_mask(top1), .sum(p_sum), .gsum(p_g)
  );

  logic                  v_p_q;
  logic [Width-1:0]      p_q, z_p_q;
  logic [2*NumLanes-1:0] pg_q;
  logic [1:0]            op_p_q, mode_p_q, cin_p_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_p_q    <= 1'b0;
      p_q      <= '0;
      pg_q     <= '0;
      z_p_q    <= '0;
      op_p_q   <= 2'b00;
      mode_p_q <= 2'b00;
      cin_p_q  <= 2'b00;
    end else begin
      v_p_q <= v_in_q;
      if (v_in_q) begin
        p_q      <= p_sum;
        pg_q     <= p_g;
        z_p_q    <= z_q;
        op_p_q   <= op_q;
        mode_p_q <= mode_q;
        cin_p_q  <= cin_q;
      end
    end
  end

  // Result stage: the accumulator is reinterpreted by this sample's own lane layout.
  logic [Width-1:0]      acc_q;
  logic [NumLanes-1:0]   base2, top2;
  logic [Width-1:0]      add_b, add_sum, res_s;
  logic [2*NumLanes-1:0] add_g, res_c;
  logic [1:0]            add_cin;

  assign base2 = lane_base_mask(mode_p_q);
  assign top2  = lane_top_mask(base2);

  always_comb begin
    add_b   = (op_p_q == OP_ACC) ? acc_q : z_p_q;
    add_cin = (op_p_q == OP_SUM4C) ? cin_p_q : 2'b00;
  end

  simd_lane_adder #(.Width(Width), .NumLanes(NumLanes)) u_add_res (
    .a(p_q), .b(add_b), .ga(pg_q), .gb('0), .cin(add_cin),
    .base_mask(base2), .top_mask(top2), .sum(add_sum), .gsum(add_g)
  );

  always_comb begin
    res_s = add_sum;
    res_c = add_g;
    if (op_p_q == OP_LOAD) begin
      res_s = z_p_q;
      res_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      S            <= '0;
      cout         <= '0;
      cascade_cout <= 2'b00;
      acc_q        <= '0;
    end else begin
      out_valid <= v_p_q;
      if (v_p_q) begin
        S            <= res_s;
        cout         <= res_c;
        cascade_cout <= res_c[2*NumLanes-1 -: 2];
        if (op_p_q == OP_ACC || op_p_q == OP_LOAD) acc_q <= res_s;
      end
    end
  end

endmodule

// File: tb/tb_simd_alu4_pipe.sv
// Bench for simd_alu4_pipe at Width=16: directed hand-computed vectors, reset mid-stream,
// and a random run scored against an independent per-lane integer model.
module tb_simd_alu4_pipe;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  w_i = '0, x_i = '0, y_i = '0, z_i = '0;
  logic [1:0]    op_i = 2'b00, mode_i = 2'b00, cin_i = 2'b00;
  logic          out_valid;
  logic [W-1:0]  s_o;
  logic [7:0]    cout_o;
  logic [1:0]    cascade_o;

  int checks = 0;
  int failures = 0;
  bit sb_en = 1'b0;
  logic [W-1:0] m_acc = '0;
  logic [25:0]  exp_q[$];

  simd_alu4_pipe #(.Width(W), .NumLanes(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .W(w_i), .X(x_i), .Y(y_i), .Z(z_i),
    .op(op_i), .simd_mode(mode_i), .cin(cin_i),
    .out_valid(out_valid), .S(s_o), .cout(cout_o), .cascade_cout(cascade_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each lane summed as a plain integer, carries taken from the bits above the lane.
  task automatic model(input logic [1:0] o, input logic [1:0] m, input logic [1:0] c,
                       input logic [W-1:0] w, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] z,
                       output logic [25:0] res);
    int n, lb, segs, msk, sum;
    logic [W-1:0] s;
    logic [7:0] co;
    n = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    lb = W / n;
    segs = 4 / n;
    msk = (1 << lb) - 1;
    s = '0;
    co = '0;
    for (int l = 0; l < n; l++) begin
      sum = (int'(w >> (l*lb)) & msk) + (int'(x >> (l*lb)) & msk) + (int'(y >> (l*lb)) & msk);
      sum += (o == 2'b10) ? (int'(m_acc >> (l*lb)) & msk) : (int'(z >> (l*lb)) & msk);
      if (o == 2'b01 && l == 0) sum += int'(c);
      s = s | (W'(sum & msk) << (l*lb));
      co[2*(l*segs + segs - 1) +: 2] = 2'(sum >> lb);
    end
    if (o == 2'b11) begin
      s = z;
      co = '0;
    end
    if (o == 2'b10 || o == 2'b11) m_acc = s;
    res = {co[7:6], co, s};
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [1:0] m,
                       input logic [1:0] c, input logic [W-1:0] w, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] z);
    logic [25:0] e;
    in_valid = v; op_i = o; mode_i = m; cin_i = c;
    w_i = w; x_i = x; y_i = y; z_i = z;
    if (sb_en && v) begin
      model(o, m, c, w, x, y, z, e);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb_en && out_valid) begin
      if (exp_q.size() == 0) check("sb_unexpected_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("sb_result", {cascade_o, cout_o, s_o}, e);
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          W'($urandom), W'($urandom), W'($urandom), W'($urandom));
  endtask

  initial begin
    logic v;
    logic [W-1:0] rw, rx, ry, rz;

    reset = 1'b1;
    idle(); idle();
    reset = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_s", s_o, 0);
    check("reset_cout", cout_o, 0);
    check("reset_cascade", cascade_o, 0);

    // Four 4-bit lanes, all ones: 4*15 = 0x3C per lane.
    drive(1'b1, 2'b00, 2'b10, 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    idle();
    check("sum4_4l_latency", out_valid, 0);
    idle();
    check("sum4_4l_valid", out_valid, 1);
    check("sum4_4l_s", s_o, 16'hCCCC);
    check("sum4_4l_cout", cout_o, 8'hFF);
    check("sum4_4l_cascade", cascade_o, 2'b11);
    idle();
    check("bubble_valid", out_valid, 0);
    check("bubble_s_hold", s_o, 16'hCCCC);

    // One 16-bit lane: 1 + 3*0xFFFF + 3 = 0x30001.
    drive(1'b1, 2'b01, 2'b00, 2'b11, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    idle(); idle();
    check("sum4c_1l_valid", out_valid, 1);
    check("sum4c_1l_s", s_o, 16'h0001);
    check("sum4c_1l_cout", cout_o, 8'hC0);
    check("sum4c_1l_cascade", cascade_o, 2'b11);

    // Reserved mode behaves as one lane.
    drive(1'b1, 2'b01, 2'b11, 2'b11, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    idle(); idle();
    check("rsvd_valid", out_valid, 1);
    check("rsvd_s", s_o, 16'h0001);
    check("rsvd_cout", cout_o, 8'hC0);
    check("rsvd_cascade", cascade_o, 2'b11);

    // Two 8-bit lanes, back-to-back LOAD then ACC, ACC; Z of the ACC samples must be ignored.
    drive(1'b1, 2'b11, 2'b01, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h00FF);
    drive(1'b1, 2'b10, 2'b01, 2'b11, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF);
    drive(1'b1, 2'b10, 2'b01, 2'b11, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF);
    check("load_valid", out_valid, 1);
    check("load_s", s_o, 16'h00FF);
    check("load_cout", cout_o, 8'h00);
    idle();
    check("acc1_valid", out_valid, 1);
    check("acc1_s", s_o, 16'h0000);
    check("acc1_cout", cout_o, 8'h04);
    check("acc1_cascade", cascade_o, 2'b00);
    idle();
    check("acc2_valid", out_valid, 1);
    check("acc2_s", s_o, 16'h0001);
    check("acc2_cout", cout_o, 8'h00);

    // Reset with two samples in flight discards them and clears the accumulator.
    drive(1'b1, 2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h1234);
    drive(1'b1, 2'b10, 2'b00, 2'b00, 16'h0007, 16'h0000, 16'h0000, 16'h0000);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("rst_flight_valid0", out_valid, 0);
    check("rst_flight_s", s_o, 16'h0000);
    idle();
    check("rst_flight_valid1", out_valid, 0);
    drive(1'b1, 2'b10, 2'b00, 2'b00, 16'h0005, 16'h0000, 16'h0000, 16'hABCD);
    check("rst_flight_valid2", out_valid, 0);
    idle(); idle();
    check("post_rst_acc_valid", out_valid, 1);
    check("post_rst_acc_s", s_o, 16'h0005);
    check("post_rst_acc_cout", cout_o, 8'h00);

    // Random run against the model, starting from a clean accumulator.
    reset = 1'b1;
    idle();
    reset = 1'b0;
    m_acc = '0;
    sb_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      rw = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
      rx = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
      rz = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
      drive(v, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            rw, rx, ry, rz);
    end
    for (int i = 0; i < 4; i++) idle();
    check("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
